// File: rtl/sd_init_seq.sv
// SPI-mode SD card power-up sequencer.
// Walks dummy clocks, CMD0, CMD8, CMD55/ACMD41 and CMD58/CMD16 through the command/response stage.
module sd_init_seq #(
  parameter int DUMMY_CYCLES = 80,
  parameter int CMD0_RETRY   = 8,
  parameter int ACMD41_RETRY = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  error_code,
  output logic        card_v2,
  output logic        card_hc,
  output logic        cs_n,
  output logic        dummy_en,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  output logic        cmd_start,
  input  logic        cmd_finish,
  input  logic [39:0] cmd_response
);

  localparam int DW = $clog2(DUMMY_CYCLES + 1);
  localparam int CW = $clog2(CMD0_RETRY + 1);
  localparam int AW = $clog2(ACMD41_RETRY + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_CMD16, S_DONE, S_ERROR
  } state_t;

  // Every command runs the same four-step handshake with the command/response stage.
  typedef enum logic [1:0] {PH_SETUP, PH_ARM, PH_WAIT, PH_DRAIN} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [DW-1:0] dummy_cnt, dummy_cnt_n;
  logic [CW-1:0] cmd0_cnt, cmd0_cnt_n;
  logic [AW-1:0] acmd_cnt, acmd_cnt_n;
  logic [39:0]   resp_q, resp_q_n;
  logic          busy_n, done_n, error_n, card_v2_n, card_hc_n, cs_n_n, dummy_en_n, cmd_start_n;
  logic [2:0]    error_code_n;
  logic [5:0]    cmd_index_n;
  logic [31:0]   cmd_argument_n;
  logic          fail, finish_ok;
  logic [2:0]    fail_code;
  logic [7:0]    r1;

  assign r1 = resp_q[39:32];

  function automatic logic [5:0] index_of(input state_t s);
    case (s)
      S_CMD8:   index_of = 6'd8;
      S_CMD55:  index_of = 6'd55;
      S_ACMD41: index_of = 6'd41;
      S_CMD58:  index_of = 6'd58;
      S_CMD16:  index_of = 6'd16;
      default:  index_of = 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] arg_of(input state_t s, input logic v2);
    case (s)
      S_CMD8:   arg_of = 32'h0000_01AA;
      S_ACMD41: arg_of = v2 ? 32'h4000_0000 : 32'h0000_0000;
      S_CMD16:  arg_of = 32'h0000_0200;
      default:  arg_of = 32'h0000_0000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      phase        <= PH_SETUP;
      dummy_cnt    <= '0;
      cmd0_cnt     <= '0;
      acmd_cnt     <= '0;
      resp_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      error_code   <= 3'd0;
      card_v2      <= 1'b0;
      card_hc      <= 1'b0;
      cs_n         <= 1'b1;
      dummy_en     <= 1'b0;
      cmd_index    <= 6'd0;
      cmd_argument <= 32'd0;
      cmd_start    <= 1'b0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      dummy_cnt    <= dummy_cnt_n;
      cmd0_cnt     <= cmd0_cnt_n;
      acmd_cnt     <= acmd_cnt_n;
      resp_q       <= resp_q_n;
      busy         <= busy_n;
      done         <= done_n;
      error        <= error_n;
      error_code   <= error_code_n;
      card_v2      <= card_v2_n;
      card_hc      <= card_hc_n;
      cs_n         <= cs_n_n;
      dummy_en     <= dummy_en_n;
      cmd_index    <= cmd_index_n;
      cmd_argument <= cmd_argument_n;
      cmd_start    <= cmd_start_n;
    end
  end

  always_comb begin
    state_n        = state;
    phase_n        = phase;
    dummy_cnt_n    = dummy_cnt;
    cmd0_cnt_n     = cmd0_cnt;
    acmd_cnt_n     = acmd_cnt;
    resp_q_n       = resp_q;
    busy_n         = busy;
    done_n         = done;
    error_n        = error;
    error_code_n   = error_code;
    card_v2_n      = card_v2;
    card_hc_n      = card_hc;
    cs_n_n         = cs_n;
    dummy_en_n     = dummy_en;
    cmd_index_n    = cmd_index;
    cmd_argument_n = cmd_argument;
    cmd_start_n    = cmd_start;
    fail           = 1'b0;
    fail_code      = 3'd0;
    finish_ok      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n      = S_DUMMY;
          phase_n      = PH_SETUP;
          busy_n       = 1'b1;
          dummy_en_n   = 1'b1;
          cs_n_n       = 1'b1;
          error_code_n = 3'd0;
          card_v2_n    = 1'b0;
          card_hc_n    = 1'b0;
          dummy_cnt_n  = '0;
          cmd0_cnt_n   = '0;
          acmd_cnt_n   = '0;
        end
      end

      S_DUMMY: begin
        if (dummy_cnt == DW'(DUMMY_CYCLES - 1)) begin
          dummy_en_n = 1'b0;
          cs_n_n     = 1'b0;
          state_n    = S_CMD0;
        end else begin
          dummy_cnt_n = dummy_cnt + DW'(1);
        end
      end

      S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD58, S_CMD16: begin
        case (phase)
          PH_SETUP: begin
            cmd_index_n    = index_of(state);
            cmd_argument_n = arg_of(state, card_v2);
            phase_n        = PH_ARM;
          end
          PH_ARM: begin
            if (!cmd_finish) begin
              cmd_start_n = 1'b1;
              phase_n     = PH_WAIT;
            end
          end
          PH_WAIT: begin
            if (cmd_finish) begin
              resp_q_n    = cmd_response;
              cmd_start_n = 1'b0;
              phase_n     = PH_DRAIN;
            end
          end
          default: begin
            // The response is only judged once the stage has released its finish flag.
            if (!cmd_finish) begin
              phase_n = PH_SETUP;
              case (state)
                S_CMD0: begin
                  if (r1 == 8'h01) state_n = S_CMD8;
                  else if (int'(cmd0_cnt) + 1 >= CMD0_RETRY) begin
                    fail = 1'b1; fail_code = 3'd1;
                  end else cmd0_cnt_n = cmd0_cnt + CW'(1);
                end
                S_CMD8: begin
                  if (r1 == 8'h01 && resp_q[11:0] == 12'h1AA) begin
                    card_v2_n = 1'b1; state_n = S_CMD55;
                  end else if (r1[2] && !r1[7]) begin
                    card_v2_n = 1'b0; state_n = S_CMD55;
                  end else begin
                    fail = 1'b1; fail_code = 3'd2;
                  end
                end
                S_CMD55: begin
                  if ((r1 & 8'hFE) == 8'h00) state_n = S_ACMD41;
                  else begin
                    fail = 1'b1; fail_code = 3'd3;
                  end
                end
                S_ACMD41: begin
                  if (r1 == 8'h00) state_n = card_v2 ? S_CMD58 : S_CMD16;
                  else if (r1 == 8'h01) begin
                    if (int'(acmd_cnt) + 1 >= ACMD41_RETRY) begin
                      fail = 1'b1; fail_code = 3'd4;
                    end else begin
                      acmd_cnt_n = acmd_cnt + AW'(1);
                      state_n    = S_CMD55;
                    end
                  end else begin
                    fail = 1'b1; fail_code = 3'd3;
                  end
                end
                S_CMD58: begin
                  if (r1 == 8'h00) begin
                    card_hc_n = resp_q[30]; finish_ok = 1'b1;
                  end else begin
                    fail = 1'b1; fail_code = 3'd5;
                  end
                end
                default: begin
                  if (r1 == 8'h00) begin
                    card_hc_n = 1'b0; finish_ok = 1'b1;
                  end else begin
                    fail = 1'b1; fail_code = 3'd5;
                  end
                end
              endcase
            end
          end
        endcase
      end

      S_DONE: begin
        if (!start) begin
          state_n = S_IDLE;
          done_n  = 1'b0;
        end
      end

      S_ERROR: begin
        if (!start) begin
          state_n = S_IDLE;
          error_n = 1'b0;
        end
      end

      default: begin
        state_n     = S_IDLE;
        phase_n     = PH_SETUP;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        error_n     = 1'b0;
        cs_n_n      = 1'b1;
        dummy_en_n  = 1'b0;
        cmd_start_n = 1'b0;
      end
    endcase

    if (fail) begin
      state_n      = S_ERROR;
      error_n      = 1'b1;
      busy_n       = 1'b0;
      cs_n_n       = 1'b1;
      error_code_n = fail_code;
    end else if (finish_ok) begin
      state_n = S_DONE;
      done_n  = 1'b1;
      busy_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// Directed bench for sd_init_seq with a scripted command/response stage model.
module tb_sd_init_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done, error, card_v2, card_hc, cs_n, dummy_en, cmd_start;
  logic [2:0]  error_code;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        cmd_finish;
  logic [39:0] cmd_response;

  int total = 0;
  int bad = 0;
  int bad_ctx = 0;
  int acmd_seen = 0;

  logic [39:0] script[$];
  logic [5:0]  log_idx[$];
  logic [31:0] log_arg[$];
  logic [5:0]  exp_idx[$];
  logic [31:0] exp_arg[$];

  sd_init_seq #(.DUMMY_CYCLES(80), .CMD0_RETRY(8), .ACMD41_RETRY(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .error_code(error_code), .card_v2(card_v2), .card_hc(card_hc), .cs_n(cs_n),
    .dummy_en(dummy_en), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
    .cmd_start(cmd_start), .cmd_finish(cmd_finish), .cmd_response(cmd_response)
  );

  always #5 clk = ~clk;

  // Command/response stage: logs each issued command, answers from the script after a short latency.
  initial begin
    cmd_finish   = 1'b0;
    cmd_response = '0;
    forever begin
      @(negedge clk);
      if (cmd_start && !cmd_finish) begin
        log_idx.push_back(cmd_index);
        log_arg.push_back(cmd_argument);
        if (cs_n !== 1'b0 || dummy_en !== 1'b0) bad_ctx++;
        if (cmd_index == 6'd41) acmd_seen++;
        repeat (3) @(negedge clk);
        if (script.size() > 0) cmd_response = script.pop_front();
        else cmd_response = {40{1'b1}};
        cmd_finish = 1'b1;
        for (int i = 0; i < 50 && cmd_start; i++) @(negedge clk);
        @(negedge clk);
        cmd_finish = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s);
    @(negedge clk);
    start = s;
  endtask

  task automatic waitFinish(input string tag);
    for (int i = 0; i < 4000 && !(done || error); i++) @(negedge clk);
    checkOutput({tag, "_finished"}, 40'(done | error), 40'd1);
  endtask

  task automatic checkLog(input string tag);
    checkOutput({tag, "_ncmd"}, 40'(log_idx.size()), 40'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < log_idx.size(); i++) begin
      checkOutput($sformatf("%s_idx%0d", tag, i), 40'(log_idx[i]), 40'(exp_idx[i]));
      checkOutput($sformatf("%s_arg%0d", tag, i), 40'(log_arg[i]), 40'(exp_arg[i]));
    end
    checkOutput({tag, "_cmdctx"}, 40'(bad_ctx), 40'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, 40'(busy), 40'd0);
    checkOutput({tag, "_done"}, 40'(done), 40'd0);
    checkOutput({tag, "_error"}, 40'(error), 40'd0);
    checkOutput({tag, "_code"}, 40'(error_code), 40'd0);
    checkOutput({tag, "_v2"}, 40'(card_v2), 40'd0);
    checkOutput({tag, "_hc"}, 40'(card_hc), 40'd0);
    checkOutput({tag, "_csn"}, 40'(cs_n), 40'd1);
    checkOutput({tag, "_dummy"}, 40'(dummy_en), 40'd0);
    checkOutput({tag, "_idx"}, 40'(cmd_index), 40'd0);
    checkOutput({tag, "_arg"}, 40'(cmd_argument), 40'd0);
    checkOutput({tag, "_start"}, 40'(cmd_start), 40'd0);
  endtask

  task automatic clearRun();
    applyStimulus(1'b0);
    repeat (3) @(negedge clk);
    log_idx.delete(); log_arg.delete(); script.delete();
    exp_idx.delete(); exp_arg.delete();
    acmd_seen = 0;
    bad_ctx   = 0;
  endtask

  task automatic loadV2Script();
    script = '{40'h01_0000_0000, 40'h01_0000_01AA, 40'h00_0000_0000,
               40'h00_0000_0000, 40'h00_C0FF_8000};
    exp_idx = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd58};
    exp_arg = '{32'h0, 32'h1AA, 32'h0, 32'h4000_0000, 32'h0};
  endtask

  initial begin
    int dn, csbad;
    reset = 1'b0;
    start = 1'b0;
    #12;
    checkResetValues("por");
    @(negedge clk);
    reset = 1'b1;

    // v2 high-capacity card, with the dummy phase measured on the way in.
    loadV2Script();
    applyStimulus(1'b1);
    dn = 0; csbad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dummy_en) begin
        dn++;
        if (cs_n !== 1'b1) csbad++;
      end else if (dn > 0) break;
    end
    checkOutput("dummy_len", 40'(dn), 40'd80);
    checkOutput("dummy_csn", 40'(csbad), 40'd0);
    checkOutput("dummy_end_csn", 40'(cs_n), 40'd0);
    checkOutput("dummy_busy", 40'(busy), 40'd1);
    checkOutput("dummy_nocmd", 40'(log_idx.size()), 40'd0);
    waitFinish("v2");
    checkOutput("v2_done", 40'(done), 40'd1);
    checkOutput("v2_error", 40'(error), 40'd0);
    checkOutput("v2_cardv2", 40'(card_v2), 40'd1);
    checkOutput("v2_cardhc", 40'(card_hc), 40'd1);
    checkOutput("v2_busy", 40'(busy), 40'd0);
    checkOutput("v2_csn", 40'(cs_n), 40'd0);
    checkLog("v2");
    repeat (20) @(negedge clk);
    checkOutput("v2_hold_done", 40'(done), 40'd1);
    checkOutput("v2_hold_nocmd", 40'(log_idx.size()), 40'd5);
    clearRun();
    checkOutput("v2_done_clear", 40'(done), 40'd0);

    // v1 card: CMD8 rejected as illegal, ACMD41 busy twice, then CMD16.
    script = '{40'h01_0000_0000, 40'h05_FFFF_FFFF, 40'h01_0000_0000, 40'h01_0000_0000,
               40'h01_0000_0000, 40'h01_0000_0000, 40'h01_0000_0000, 40'h00_0000_0000,
               40'h00_0000_0000};
    exp_idx = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd16};
    exp_arg = '{32'h0, 32'h1AA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h200};
    applyStimulus(1'b1);
    waitFinish("v1");
    checkOutput("v1_done", 40'(done), 40'd1);
    checkOutput("v1_cardv2", 40'(card_v2), 40'd0);
    checkOutput("v1_cardhc", 40'(card_hc), 40'd0);
    checkLog("v1");
    clearRun();

    // CMD0 never answers.
    for (int i = 0; i < 8; i++) begin
      exp_idx.push_back(6'd0);
      exp_arg.push_back(32'h0);
    end
    applyStimulus(1'b1);
    waitFinish("c0to");
    checkOutput("c0to_error", 40'(error), 40'd1);
    checkOutput("c0to_code", 40'(error_code), 40'd1);
    checkOutput("c0to_csn", 40'(cs_n), 40'd1);
    checkOutput("c0to_busy", 40'(busy), 40'd0);
    checkLog("c0to");
    clearRun();
    checkOutput("c0to_err_clear", 40'(error), 40'd0);
    checkOutput("c0to_code_kept", 40'(error_code), 40'd1);

    // ACMD41 stays idle until the iteration limit.
    script = '{40'h01_0000_0000, 40'h01_0000_01AA};
    exp_idx = '{6'd0, 6'd8};
    exp_arg = '{32'h0, 32'h1AA};
    for (int i = 0; i < 4; i++) begin
      script.push_back(40'h01_0000_0000);
      script.push_back(40'h01_0000_0000);
      exp_idx.push_back(6'd55); exp_arg.push_back(32'h0);
      exp_idx.push_back(6'd41); exp_arg.push_back(32'h4000_0000);
    end
    applyStimulus(1'b1);
    waitFinish("a41");
    checkOutput("a41_error", 40'(error), 40'd1);
    checkOutput("a41_code", 40'(error_code), 40'd4);
    checkLog("a41");
    clearRun();

    // Reset lands in the middle of the third ACMD41.
    script = '{40'h01_0000_0000, 40'h01_0000_01AA};
    for (int i = 0; i < 8; i++) script.push_back(40'h01_0000_0000);
    applyStimulus(1'b1);
    for (int i = 0; i < 4000 && acmd_seen < 3; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("rst_reached", 40'(acmd_seen), 40'd3);
    checkOutput("rst_cmdstart", 40'(cmd_start), 40'd1);
    reset = 1'b0;
    #1;
    checkResetValues("rst_async");
    start = 1'b0;
    repeat (10) @(negedge clk);
    log_idx.delete(); log_arg.delete(); script.delete();
    acmd_seen = 0;
    bad_ctx   = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_nocmd", 40'(log_idx.size()), 40'd0);

    // Full v2 sequence again after the reset.
    loadV2Script();
    applyStimulus(1'b1);
    waitFinish("rerun");
    checkOutput("rerun_done", 40'(done), 40'd1);
    checkOutput("rerun_cardv2", 40'(card_v2), 40'd1);
    checkOutput("rerun_cardhc", 40'(card_hc), 40'd1);
    checkLog("rerun");
    clearRun();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
